// File: rtl/fill_class_pkg.sv
// Shared types for the fill-classification stream stage: the fill class enum and class count.
package fill_class_pkg;

  typedef enum logic [2:0] {
    FC_ZERO  = 3'd0,
    FC_ONE   = 3'd1,
    FC_X     = 3'd2,
    FC_Z     = 3'd3,
    FC_MIXED = 3'd4
  } fill_class_e;

  localparam int FC_NUM = 5;

endpackage

// File: rtl/fill_classifier.sv
// Combinational fill detector: labels a word as an all-0/all-1/all-x/all-z fill or mixed.
// FILL_CLASS_XZ_EN enables the all-x / all-z classes; without it those words are FC_MIXED.
module fill_classifier
  import fill_class_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] data_i,
  output fill_class_e      class_o
);

  // Case-equality so that x and z bits are matched literally rather than propagated.
  always_comb begin
    class_o = FC_MIXED;
    if (data_i === '0) begin
      class_o = FC_ZERO;
    end else if (data_i === '1) begin
      class_o = FC_ONE;
`ifdef FILL_CLASS_XZ_EN
    end else if (data_i === 'x) begin
      class_o = FC_X;
    end else if (data_i === 'z) begin
      class_o = FC_Z;
`endif
    end
  end

endmodule

// File: rtl/fill_class_stage.sv
// Registered valid/ready stage with one skid entry that forwards each word with its fill class
// and keeps saturating per-class counters. FILL_CLASS_XZ_EN enables the x/z classes and counters.
module fill_class_stage
  import fill_class_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output fill_class_e      out_class,
  output logic [CNT_W-1:0] cnt_zero,
  output logic [CNT_W-1:0] cnt_one,
  output logic [CNT_W-1:0] cnt_x,
  output logic [CNT_W-1:0] cnt_z,
  output logic [CNT_W-1:0] cnt_mixed
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  fill_class_e in_class;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  fill_class_e      out_class_q, out_class_d;
  logic             skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0] skid_data_q,  skid_data_d;
  fill_class_e      skid_class_q, skid_class_d;
  logic             in_ready_q;
  logic [CNT_W-1:0] cnt_q [FC_NUM];
  logic [CNT_W-1:0] cnt_d [FC_NUM];

  logic accept;
  logic out_fire;
  logic out_free;

  fill_classifier #(.WIDTH(WIDTH)) u_classifier (
    .data_i  (in_data),
    .class_o (in_class)
  );

  assign accept   = in_valid & in_ready_q;
  assign out_fire = out_valid_q & out_ready;
  assign out_free = ~out_valid_q | out_ready;

  // Input side -> output register / skid entry
  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_class_d  = out_class_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_class_d = skid_class_q;
    if (skid_valid_q) begin
      // in_ready is low whenever the skid holds a word, so only a drain can happen here.
      if (out_fire) begin
        out_data_d   = skid_data_q;
        out_class_d  = skid_class_q;
        skid_valid_d = 1'b0;
      end
    end else if (accept) begin
      if (out_free) begin
        out_valid_d = 1'b1;
        out_data_d  = in_data;
        out_class_d = in_class;
      end else begin
        skid_valid_d = 1'b1;
        skid_data_d  = in_data;
        skid_class_d = in_class;
      end
    end else if (out_fire) begin
      out_valid_d = 1'b0;
    end
  end

  always_comb begin
    for (int c = 0; c < FC_NUM; c++) begin
      cnt_d[c] = cnt_q[c];
      if (clr) begin
        cnt_d[c] = '0;
      end else if (accept && (in_class == fill_class_e'(c))) begin
        cnt_d[c] = sat_inc(cnt_q[c]);
      end
    end
`ifndef FILL_CLASS_XZ_EN
    cnt_d[FC_X] = '0;
    cnt_d[FC_Z] = '0;
`endif
  end

  // Output register, control and counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_class_q  <= FC_ZERO;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b0;
      for (int c = 0; c < FC_NUM; c++) begin
        cnt_q[c] <= '0;
      end
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_class_q  <= out_class_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= ~skid_valid_d;
      for (int c = 0; c < FC_NUM; c++) begin
        cnt_q[c] <= cnt_d[c];
      end
    end
  end

  // Skid payload is qualified by skid_valid_q, so it needs no reset.
  always_ff @(posedge clk) begin
    skid_data_q  <= skid_data_d;
    skid_class_q <= skid_class_d;
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_class = out_class_q;
  assign cnt_zero  = cnt_q[FC_ZERO];
  assign cnt_one   = cnt_q[FC_ONE];
  assign cnt_x     = cnt_q[FC_X];
  assign cnt_z     = cnt_q[FC_Z];
  assign cnt_mixed = cnt_q[FC_MIXED];

endmodule

// File: tb/tb_fill_class_stage.sv
// Directed and randomized bench for fill_class_stage; honours FILL_CLASS_XZ_EN when defined.
`timescale 1ns/1ps
module tb_fill_class_stage;
  import fill_class_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        clr;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  fill_class_e out_class;
  logic [15:0] cnt_zero, cnt_one, cnt_x, cnt_z, cnt_mixed;

  logic        s_in_ready;
  logic        s_out_valid;
  logic [63:0] s_out_data;
  fill_class_e s_out_class;
  logic [1:0]  s_cnt_zero, s_cnt_one, s_cnt_x, s_cnt_z, s_cnt_mixed;

  int checks   = 0;
  int failures = 0;

  fill_class_stage #(.WIDTH(64), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_class(out_class),
    .cnt_zero(cnt_zero), .cnt_one(cnt_one), .cnt_x(cnt_x), .cnt_z(cnt_z), .cnt_mixed(cnt_mixed)
  );

  fill_class_stage #(.WIDTH(64), .CNT_W(2)) u_small (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data), .out_class(s_out_class),
    .cnt_zero(s_cnt_zero), .cnt_one(s_cnt_one), .cnt_x(s_cnt_x), .cnt_z(s_cnt_z),
    .cnt_mixed(s_cnt_mixed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic fill_class_e exp_class(input logic [63:0] w);
    if (w === '0) return FC_ZERO;
    if (w === '1) return FC_ONE;
`ifdef FILL_CLASS_XZ_EN
    if (w === 'x) return FC_X;
    if (w === 'z) return FC_Z;
`endif
    return FC_MIXED;
  endfunction

  function automatic logic [15:0] dut_cnt(input int c);
    case (c)
      0:       return cnt_zero;
      1:       return cnt_one;
      2:       return cnt_x;
      3:       return cnt_z;
      default: return cnt_mixed;
    endcase
  endfunction

  function automatic logic [63:0] rand_word();
    logic [63:0] w;
    case ($urandom_range(0, 6))
      0:       w = '0;
      1:       w = '1;
      2:       w = 'x;
      3:       w = 'z;
      4:       w = {$urandom(), $urandom()};
      5:       w = {$urandom(), 32'hxxxx_xxxx};
      default: w = {32'hzzzz_zzzz, $urandom()};
    endcase
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    clr       = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = '1; out_ready = 1'b1;
    #2;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 64'h0 || out_class !== FC_ZERO) begin
      failures++;
      $display("FAIL reset_out: valid=%b data=%h class=%0d want 0/0/0", out_valid, out_data, out_class);
    end
    checks++;
    if ((cnt_zero | cnt_one | cnt_x | cnt_z | cnt_mixed) !== 16'h0) begin
      failures++;
      $display("FAIL reset_cnt: counters %0d %0d %0d %0d %0d want all 0",
               cnt_zero, cnt_one, cnt_x, cnt_z, cnt_mixed);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_in_ready: got %b want 0", in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL release_in_ready_early: got %b want 0 before first edge", in_ready);
    end
    tick();
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL release_in_ready: got %b want 1 after first edge", in_ready);
    end
  endtask

  task automatic test_fill_sequence();
    logic [63:0] w [5];
    fill_class_e ec [5];
    int          ecnt [5];
    do_reset();
    w[0] = '0; w[1] = '1; w[2] = 'x; w[3] = 'z; w[4] = 64'h1;
    ec[0] = FC_ZERO; ec[1] = FC_ONE; ec[2] = exp_class(w[2]); ec[3] = exp_class(w[3]);
    ec[4] = FC_MIXED;
    for (int c = 0; c < 5; c++) ecnt[c] = 0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = w[i];
      ecnt[int'(ec[i])]++;
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== w[i] || out_class !== ec[i] || in_ready !== 1'b1) begin
        failures++;
        $display("FAIL seq_word%0d: valid=%b data=%h class=%0d rdy=%b want 1/%h/%0d/1",
                 i, out_valid, out_data, out_class, in_ready, w[i], ec[i]);
      end
    end
    in_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (dut_cnt(c) !== 16'(ecnt[c])) begin
        failures++;
        $display("FAIL seq_cnt%0d: got %0d want %0d", c, dut_cnt(c), ecnt[c]);
      end
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL seq_drain: out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] a, b, c;
    int          nx;
    do_reset();
    a = 'x;
    b = 64'h0123_4567_89ab_cdef;
    c = {32'hzzzz_zzzz, 32'h5a5a_5a5a};
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = a;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== a || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_first: valid=%b data=%h rdy=%b want 1/%h/1", out_valid, out_data, in_ready, a);
    end
    in_data = b;
    tick();
    checks++;
    if (in_ready !== 1'b0 || out_data !== a) begin
      failures++;
      $display("FAIL bp_skid: rdy=%b data=%h want 0/%h", in_ready, out_data, a);
    end
    in_data = c;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== a || out_class !== exp_class(a)) begin
        failures++;
        $display("FAIL bp_hold%0d: rdy=%b valid=%b data=%h class=%0d want 0/1/%h/%0d",
                 i, in_ready, out_valid, out_data, out_class, a, exp_class(a));
      end
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== b || out_class !== FC_MIXED || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_release_b: valid=%b data=%h class=%0d rdy=%b want 1/%h/4/1",
               out_valid, out_data, out_class, in_ready, b);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== c || out_class !== exp_class(c)) begin
      failures++;
      $display("FAIL bp_release_c: valid=%b data=%h class=%0d want 1/%h/%0d",
               out_valid, out_data, out_class, c, exp_class(c));
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_empty: out_valid=%b want 0", out_valid);
    end
    nx = (exp_class(a) == FC_MIXED ? 1 : 0) + (exp_class(c) == FC_MIXED ? 1 : 0) + 1;
    checks++;
    if (cnt_mixed !== 16'(nx)) begin
      failures++;
      $display("FAIL bp_cnt_mixed: got %0d want %0d", cnt_mixed, nx);
    end
  endtask

  task automatic test_saturate_clr();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = '1;
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (s_cnt_one !== 2'd3 || cnt_one !== 16'd5) begin
      failures++;
      $display("FAIL sat_cnt_one: small=%0d wide=%0d want 3/5", s_cnt_one, cnt_one);
    end
    in_valid = 1'b1; in_data = '0;
    tick();
    checks++;
    if (s_cnt_zero !== 2'd1 || cnt_zero !== 16'd1) begin
      failures++;
      $display("FAIL sat_cnt_zero_pre: small=%0d wide=%0d want 1/1", s_cnt_zero, cnt_zero);
    end
    clr = 1'b1;
    tick();
    clr = 1'b0; in_valid = 1'b0;
    checks++;
    if (s_cnt_zero !== 2'd0 || cnt_zero !== 16'd0 || cnt_one !== 16'd0 || s_cnt_one !== 2'd0) begin
      failures++;
      $display("FAIL clr_cnt: zero=%0d/%0d one=%0d/%0d want 0", cnt_zero, s_cnt_zero, cnt_one, s_cnt_one);
    end
    checks++;
    if (out_valid !== 1'b1 || out_data !== 64'h0 || out_class !== FC_ZERO) begin
      failures++;
      $display("FAIL clr_datapath: valid=%b data=%h class=%0d want 1/0/0", out_valid, out_data, out_class);
    end
    checks++;
    if (s_out_valid !== 1'b1 || s_out_data !== 64'h0 || s_out_class !== FC_ZERO || s_in_ready !== 1'b1 ||
        (s_cnt_x | s_cnt_z | s_cnt_mixed) !== 2'd0) begin
      failures++;
      $display("FAIL clr_small: valid=%b data=%h class=%0d rdy=%b x=%0d z=%0d m=%0d want 1/0/0/1/0/0/0",
               s_out_valid, s_out_data, s_out_class, s_in_ready, s_cnt_x, s_cnt_z, s_cnt_mixed);
    end
    tick();
    checks++;
    if (cnt_zero !== 16'd0) begin
      failures++;
      $display("FAIL clr_after: cnt_zero=%0d want 0", cnt_zero);
    end
  endtask

  task automatic test_midstream_reset();
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 'z;
    tick();
    in_data = '1;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0 || cnt_one !== 16'd1) begin
      failures++;
      $display("FAIL mid_preload: valid=%b rdy=%b one=%0d want 1/0/1", out_valid, in_ready, cnt_one);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 64'h0 || in_ready !== 1'b0 ||
        (cnt_zero | cnt_one | cnt_x | cnt_z | cnt_mixed) !== 16'h0) begin
      failures++;
      $display("FAIL mid_async: valid=%b data=%h rdy=%b cnt_or=%0d want 0/0/0/0",
               out_valid, out_data, in_ready, cnt_zero | cnt_one | cnt_x | cnt_z | cnt_mixed);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL mid_release: rdy=%b valid=%b want 1/0", in_ready, out_valid);
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL mid_discard: out_valid=%b want 0 (skid word must be gone)", out_valid);
    end
  endtask

  task automatic test_random();
    logic [63:0] sb_data [$];
    fill_class_e sb_class [$];
    int          ecnt [5];
    int          accepted;
    int          cycles;
    int          sum;
    logic        acc;
    logic        stall_prev;
    logic [63:0] held_data;
    fill_class_e held_class;
    logic [63:0] exp_d;
    fill_class_e exp_c;
    do_reset();
    for (int c = 0; c < 5; c++) ecnt[c] = 0;
    accepted = 0; cycles = 0; stall_prev = 1'b0;
    held_data = '0; held_class = FC_ZERO;
    while ((accepted < 1000 || sb_data.size() > 0) && cycles < 20000) begin
      if (!in_valid && accepted < 1000 && $urandom_range(0, 3) != 0) begin
        in_valid = 1'b1;
        in_data  = rand_word();
      end
      out_ready = (accepted >= 1000) ? 1'b1 : ($urandom_range(0, 3) != 0);
      if (stall_prev) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== held_data || out_class !== held_class) begin
          failures++;
          $display("FAIL rnd_stable cycle %0d: valid=%b data=%h class=%0d want 1/%h/%0d",
                   cycles, out_valid, out_data, out_class, held_data, held_class);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (sb_data.size() == 0) begin
          failures++;
          $display("FAIL rnd_extra cycle %0d: got word %h with empty scoreboard", cycles, out_data);
        end else begin
          exp_d = sb_data.pop_front();
          exp_c = sb_class.pop_front();
          if (out_data !== exp_d || out_class !== exp_c) begin
            failures++;
            $display("FAIL rnd_word cycle %0d: data=%h class=%0d want %h/%0d",
                     cycles, out_data, out_class, exp_d, exp_c);
          end
        end
      end
      acc = in_valid && in_ready;
      if (acc) begin
        sb_data.push_back(in_data);
        sb_class.push_back(exp_class(in_data));
        ecnt[int'(exp_class(in_data))]++;
        accepted++;
      end
      stall_prev = out_valid && !out_ready;
      held_data  = out_data;
      held_class = out_class;
      tick();
      if (acc) in_valid = 1'b0;
      cycles++;
    end
    in_valid = 1'b0;
    checks++;
    if (cycles >= 20000 || sb_data.size() != 0) begin
      failures++;
      $display("FAIL rnd_budget: cycles=%0d accepted=%0d pending=%0d want <20000/1000/0",
               cycles, accepted, sb_data.size());
    end
    sum = int'(cnt_zero) + int'(cnt_one) + int'(cnt_x) + int'(cnt_z) + int'(cnt_mixed);
    checks++;
    if (sum != accepted) begin
      failures++;
      $display("FAIL rnd_cnt_sum: got %0d want %0d", sum, accepted);
    end
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (dut_cnt(c) !== 16'(ecnt[c])) begin
        failures++;
        $display("FAIL rnd_cnt%0d: got %0d want %0d", c, dut_cnt(c), ecnt[c]);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    test_reset();
    test_fill_sequence();
    test_backpressure();
    test_saturate_clr();
    test_midstream_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
